seq_edge_8b_level_rebuild: RTL and testbench
============================================

Name: seq_edge_8b_level_rebuild

Overview:
Reverse of the 8-bit any-edge detector. It consumes per-bit transition vectors (1 = that bit toggled) and rebuilds the original 8-bit signal by accumulating them into a level register. Reconstructed levels are delivered through a 2-entry valid/ready output queue. A saturating toggle counter supports link-quality monitoring. It sits on the receive side of an edge-compressed status channel.

Parameters:
NBITS, 8, width of the transition vector, the level register and the output.
CNT_W, 16, width of the saturating toggle counter.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
in_val  input  1  transition vector valid.
in_rdy  output  1  block can accept a transition vector.
in_edges  input  NBITS  transition vector; bit i = 1 means bit i toggled.
load_en  input  1  synchronous baseline load of the level register.
load_val  input  NBITS  baseline level, used when load_en = 1.
out_val  output  1  reconstructed level valid.
out_rdy  input  1  downstream accepts out.
out  output  NBITS  reconstructed level at queue head.
toggle_cnt  output  CNT_W  saturating total of accepted toggled bits.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n = 0:
  - lvl = 0, queue count = 0, both queue entries = 0, toggle_cnt = 0.
  - Outputs read out_val = 0, out = 0, in_rdy = 0.
- Reset release: in_rdy rises in the first cycle after rst_n deasserts.
- Input handshake: fire_in = in_val & in_rdy. in_rdy = rst_n & (count < 2).
  - in_rdy has no combinational dependence on out_rdy.
  - in_edges is ignored when fire_in = 0.
- Level update, with base = load_en ? load_val : lvl:
  - fire_in = 1: lvl <= base ^ in_edges, and the same value is pushed to the queue tail.
  - fire_in = 0 and load_en = 1: lvl <= load_val, nothing pushed.
  - Otherwise lvl holds.
- Latency: a vector accepted at edge N appears on out, with out_val = 1, after edge N if the queue was empty. The path is one register stage; in_edges never reaches out combinationally.
- Output handshake: out_val = (count != 0), out = head entry, fire_out = out_val & out_rdy pops the head.
  - While out_val = 1 and out_rdy = 0, out holds stable.
- Queue, 2 entries in FIFO order:
  - Push only: count + 1.
  - Pop only: count - 1, second entry moves to head.
  - Push and pop with count = 1: count stays 1, head = new value.
  - Push at count = 2: impossible because in_rdy = 0.
  - Pop at count = 0: impossible because out_val = 0.
- Toggle counter, with pc = popcount(in_edges), range 0..NBITS:
  - load_en = 1: toggle_cnt <= (fire_in ? pc : 0).
  - Else on fire_in: toggle_cnt <= min(toggle_cnt + pc, 2^CNT_W - 1). Compute the sum one bit wider, then saturate; no wrap.
  - Otherwise holds.
- load_en does not flush the queue. Entries already queued are delivered unchanged.
- Reset mid-operation: any rst_n low immediately clears the queue. All queued levels and counts are lost. in_rdy and out_val drop asynchronously.
- No X-propagation: all state is reset; the queue storage is reset to 0.

Test Plan:
1. Reset then stream: in_edges = 0x01, 0x03, 0x80 back-to-back with out_rdy = 1 -> out = 0x01, 0x02, 0x82 on consecutive cycles, each one cycle after acceptance; toggle_cnt = 1, 3, 4.
2. Backpressure: out_rdy = 0, in_val = 1, in_edges = 0xFF three times -> two accepted (out holds 0xFF, queue holds 0xFF then 0x00), in_rdy = 0 on the third. Then raise out_rdy -> 0xFF, 0x00, then the third vector gives 0xFF, in order with none lost.
3. Load: load_en = 1, load_val = 0xA5, no fire -> no output. Next, in_edges = 0x0F -> out = 0xAA, toggle_cnt = 4.
4. Simultaneous load and fire: load_val = 0x3C, in_edges = 0x01 in the same cycle -> out = 0x3D, lvl = 0x3D, toggle_cnt = 1.
5. Saturation: CNT_W = 4, send 0xFF twice -> toggle_cnt = 8, then 15. A further 0x01 leaves it at 15.
6. Async reset mid-stream: two entries queued with out_rdy = 0, pulse rst_n low between clock edges -> out_val, in_rdy and toggle_cnt go to 0 without a clock edge. After release, in_edges = 0x10 -> out = 0x10.

Source files
------------

// File: rtl/seq_edge_8b_level_rebuild.sv
// Level rebuilder: accumulates per-bit transition vectors into a level
// register and hands each rebuilt level to a 2-entry valid/ready queue.
// A saturating counter tracks the total number of accepted toggled bits.
module seq_edge_8b_level_rebuild #(
  parameter int NBITS = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_edges,
  input  logic             load_en,
  input  logic [NBITS-1:0] load_val,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out,
  output logic [CNT_W-1:0] toggle_cnt
);

  // Level register and queue storage (head = q_head, second = q_tail)
  logic [NBITS-1:0] lvl;
  logic [NBITS-1:0] q_head;
  logic [NBITS-1:0] q_tail;
  logic [1:0]       q_count;

  logic             fire_in;
  logic             fire_out;
  logic [NBITS-1:0] base_lvl;
  logic [NBITS-1:0] next_lvl;
  logic [CNT_W:0]   pop_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // Handshakes: in_rdy depends only on reset and occupancy, never on out_rdy
  always_comb begin
    in_rdy   = rst_n & (q_count < 2'd2);
    out_val  = (q_count != 2'd0);
    out      = q_head;
    fire_in  = in_val & in_rdy;
    fire_out = out_val & out_rdy;
  end

  // New level: apply the toggles on top of either the baseline or the held level
  always_comb begin
    base_lvl = load_en ? load_val : lvl;
    next_lvl = base_lvl ^ in_edges;
  end

  // Popcount of the transition vector, one bit wider than the counter so the
  // sum below cannot wrap before saturation is applied
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NBITS; i++) begin
      pop_cnt = pop_cnt + {{CNT_W{1'b0}}, in_edges[i]};
    end
  end

  // Next toggle count: a load restarts counting, otherwise add and clamp
  always_comb begin
    cnt_sum  = {1'b0, toggle_cnt} + pop_cnt;
    cnt_next = toggle_cnt;
    if (load_en) begin
      cnt_next = fire_in ? pop_cnt[CNT_W-1:0] : '0;
    end else if (fire_in) begin
      cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  // Level register: accepted vectors and baseline loads update it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
    end else if (fire_in) begin
      lvl <= next_lvl;
    end else if (load_en) begin
      lvl <= load_val;
    end
  end

  // Two-entry FIFO; a load never disturbs entries already queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= 2'd0;
    end else begin
      case ({fire_in, fire_out})
        2'b10: begin
          if (q_count == 2'd0) begin
            q_head <= next_lvl;
          end else begin
            q_tail <= next_lvl;
          end
          q_count <= q_count + 2'd1;
        end
        2'b01: begin
          q_head  <= q_tail;
          q_count <= q_count - 2'd1;
        end
        2'b11: begin
          // Push while popping is only possible at one entry: the new value
          // replaces the departing head and occupancy stays the same
          q_head <= next_lvl;
        end
        default: begin
        end
      endcase
    end
  end

  // Toggle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else begin
      toggle_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_seq_edge_8b_level_rebuild.sv
// Directed bench for seq_edge_8b_level_rebuild; a second instance with a
// 4-bit counter exercises saturation.
module tb_seq_edge_8b_level_rebuild;

  logic        clk;
  logic        rst_n;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in_edges;
  logic        load_en;
  logic [7:0]  load_val;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out;
  logic [15:0] toggle_cnt;

  logic        s_in_val;
  logic        s_in_rdy;
  logic [7:0]  s_in_edges;
  logic        s_load_en;
  logic [7:0]  s_load_val;
  logic        s_out_val;
  logic        s_out_rdy;
  logic [7:0]  s_out;
  logic [3:0]  s_toggle_cnt;

  int checks;
  int failures;

  seq_edge_8b_level_rebuild #(.NBITS(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
    .in_edges(in_edges), .load_en(load_en), .load_val(load_val),
    .out_val(out_val), .out_rdy(out_rdy), .out(out), .toggle_cnt(toggle_cnt)
  );

  seq_edge_8b_level_rebuild #(.NBITS(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_val(s_in_val), .in_rdy(s_in_rdy),
    .in_edges(s_in_edges), .load_en(s_load_en), .load_val(s_load_val),
    .out_val(s_out_val), .out_rdy(s_out_rdy), .out(s_out), .toggle_cnt(s_toggle_cnt)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_val = 1'b0; load_en = 1'b0; out_rdy = 1'b0;
    in_edges = 8'h00; load_val = 8'h00;
    s_in_val = 1'b0; s_load_en = 1'b0; s_out_rdy = 1'b0;
    s_in_edges = 8'h00; s_load_val = 8'h00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_val = 1'b1; in_edges = 8'hFF; load_en = 1'b0; out_rdy = 1'b1;
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_val got=%b exp=0", out_val); end
    checks++; if (out !== 8'h00) begin failures++; $display("[TB] FAIL reset_out got=%h exp=00", out); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_rdy got=%b exp=0", in_rdy); end
    checks++; if (toggle_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", toggle_cnt); end
    in_val = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("[TB] FAIL release_in_rdy got=%b exp=1", in_rdy); end
  endtask

  task automatic test_stream();
    logic [7:0]  vec [3] = '{8'h01, 8'h03, 8'h80};
    logic [7:0]  exp_out [3] = '{8'h01, 8'h02, 8'h82};
    logic [15:0] exp_cnt [3] = '{16'd1, 16'd3, 16'd4};
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1; in_edges = vec[i];
      step();
      checks++; if (out_val !== 1'b1 || out !== exp_out[i]) begin failures++; $display("[TB] FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, out_val, out, exp_out[i]); end
      checks++; if (toggle_cnt !== exp_cnt[i]) begin failures++; $display("[TB] FAIL stream_cnt[%0d] got=%0d exp=%0d", i, toggle_cnt, exp_cnt[i]); end
    end
    in_val = 1'b0;
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain got=%b exp=0", out_val); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy = 1'b0; in_val = 1'b1; in_edges = 8'hFF;
    step();
    step();
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_in_rdy got=%b exp=0", in_rdy); end
    checks++; if (out !== 8'hFF || out_val !== 1'b1) begin failures++; $display("[TB] FAIL bp_head got=%b/%h exp=1/ff", out_val, out); end
    step();
    checks++; if (out !== 8'hFF) begin failures++; $display("[TB] FAIL bp_hold got=%h exp=ff", out); end
    checks++; if (toggle_cnt !== 16'd16) begin failures++; $display("[TB] FAIL bp_cnt got=%0d exp=16", toggle_cnt); end
    out_rdy = 1'b1;
    step();
    checks++; if (out !== 8'h00 || out_val !== 1'b1) begin failures++; $display("[TB] FAIL bp_second got=%b/%h exp=1/00", out_val, out); end
    step();
    checks++; if (out !== 8'hFF || out_val !== 1'b1) begin failures++; $display("[TB] FAIL bp_third got=%b/%h exp=1/ff", out_val, out); end
    in_val = 1'b0;
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain got=%b exp=0", out_val); end
    checks++; if (toggle_cnt !== 16'd24) begin failures++; $display("[TB] FAIL bp_cnt_final got=%0d exp=24", toggle_cnt); end
  endtask

  task automatic test_load();
    out_rdy = 1'b1; in_val = 1'b0; load_en = 1'b1; load_val = 8'hA5;
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("[TB] FAIL load_no_out got=%b exp=0", out_val); end
    checks++; if (toggle_cnt !== 16'd0) begin failures++; $display("[TB] FAIL load_cnt_clear got=%0d exp=0", toggle_cnt); end
    load_en = 1'b0; in_val = 1'b1; in_edges = 8'h0F;
    step();
    checks++; if (out !== 8'hAA || out_val !== 1'b1) begin failures++; $display("[TB] FAIL load_out got=%b/%h exp=1/aa", out_val, out); end
    checks++; if (toggle_cnt !== 16'd4) begin failures++; $display("[TB] FAIL load_cnt got=%0d exp=4", toggle_cnt); end
    in_val = 1'b0;
    step();
  endtask

  task automatic test_load_and_fire();
    out_rdy = 1'b1; load_en = 1'b1; load_val = 8'h3C; in_val = 1'b1; in_edges = 8'h01;
    step();
    checks++; if (out !== 8'h3D || out_val !== 1'b1) begin failures++; $display("[TB] FAIL lf_out got=%b/%h exp=1/3d", out_val, out); end
    checks++; if (toggle_cnt !== 16'd1) begin failures++; $display("[TB] FAIL lf_cnt got=%0d exp=1", toggle_cnt); end
    load_en = 1'b0; in_edges = 8'h00;
    step();
    checks++; if (out !== 8'h3D) begin failures++; $display("[TB] FAIL lf_lvl got=%h exp=3d", out); end
    checks++; if (toggle_cnt !== 16'd1) begin failures++; $display("[TB] FAIL lf_cnt_hold got=%0d exp=1", toggle_cnt); end
    in_val = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    s_out_rdy = 1'b1; s_in_val = 1'b1; s_in_edges = 8'hFF;
    step();
    checks++; if (s_toggle_cnt !== 4'd8) begin failures++; $display("[TB] FAIL sat_first got=%0d exp=8", s_toggle_cnt); end
    step();
    checks++; if (s_toggle_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_clamp got=%0d exp=15", s_toggle_cnt); end
    s_in_edges = 8'h01;
    step();
    checks++; if (s_toggle_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_hold got=%0d exp=15", s_toggle_cnt); end
    checks++; if (s_out !== 8'h01) begin failures++; $display("[TB] FAIL sat_out got=%h exp=01", s_out); end
    s_in_val = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_rdy = 1'b0; in_val = 1'b1; in_edges = 8'h01;
    step();
    in_edges = 8'h02;
    step();
    in_val = 1'b0;
    checks++; if (out_val !== 1'b1 || in_rdy !== 1'b0 || toggle_cnt !== 16'd2) begin failures++; $display("[TB] FAIL ar_pre got=%b/%b/%0d exp=1/0/2", out_val, in_rdy, toggle_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0) begin failures++; $display("[TB] FAIL ar_out_val got=%b exp=0", out_val); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("[TB] FAIL ar_in_rdy got=%b exp=0", in_rdy); end
    checks++; if (toggle_cnt !== 16'd0) begin failures++; $display("[TB] FAIL ar_cnt got=%0d exp=0", toggle_cnt); end
    #1;
    rst_n = 1'b1;
    out_rdy = 1'b1; in_val = 1'b1; in_edges = 8'h10;
    step();
    checks++; if (out !== 8'h10 || out_val !== 1'b1) begin failures++; $display("[TB] FAIL ar_after got=%b/%h exp=1/10", out_val, out); end
    in_val = 1'b0;
    step();
  endtask

  // Scenario sequence
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_val = 1'b0; in_edges = 8'h00; load_en = 1'b0; load_val = 8'h00; out_rdy = 1'b0;
    s_in_val = 1'b0; s_in_edges = 8'h00; s_load_en = 1'b0; s_load_val = 8'h00; s_out_rdy = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_load();
    test_load_and_fire();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
